// File: rtl/ksa2_result_checker.sv
// ksa2_result_checker
//   Result checker for the 2-bit Kogge-Stone adder. It turns the adder's
//   asynchronous SFQ output pulses into one 3-bit word {cout,sum1,sum0} per
//   GCLK window. Each word is compared with an expected word that was queued
//   LATENCY windows earlier, and error statistics are kept.
//
//   Optional feature macro: KSA2_RESULT_LOG_EN
//     defined   : a DEPTH-entry result log FIFO ({mismatch,got}) is built.
//     undefined : no FIFO. log_rd_data=0, log_empty=1, log_full=0 and
//                 log_overflow=0 are constant, and log_rd_en is ignored.
//
//   Ports
//     GCLK_Pad, RSTN_Pad          : window clock (rising edge closes a window),
//                                   async active-low reset
//     sum0_Pad, sum1_Pad, cout_Pad: adder output pulses
//     exp_valid, exp_word         : expected word, sampled on GCLK
//     clr                         : synchronous clear of counters and sticky flags
//     chk_valid, chk_pass,
//     got_word                    : per-compare result
//     err_count, chk_count        : saturating statistics
//     spurious                    : sticky, pulses seen with nothing expected
//     first_err_vld,
//     first_err_info              : sticky, {expected,got} of the first mismatch
//     log_rd_en, log_rd_data,
//     log_empty, log_full,
//     log_overflow                : result log FIFO (first-word-fall-through)
module ksa2_result_checker #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8
) (
  input  logic             GCLK_Pad,
  input  logic             RSTN_Pad,
  input  logic             sum0_Pad,
  input  logic             sum1_Pad,
  input  logic             cout_Pad,
  input  logic             exp_valid,
  input  logic [2:0]       exp_word,
  input  logic             clr,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [2:0]       got_word,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count,
  output logic             spurious,
  output logic             first_err_vld,
  output logic [5:0]       first_err_info,
  input  logic             log_rd_en,
  output logic [3:0]       log_rd_data,
  output logic             log_empty,
  output logic             log_full,
  output logic             log_overflow
);

  // Pulse capture adds two GCLK stages, so the expectation is delayed by the
  // same amount on top of the adder latency.
  localparam int STAGES = LATENCY + 2;

  logic       tog0, tog1, tog2;
  logic [2:0] sync1, sync2, sync3;
  logic [2:0] got;

  // One toggle flop per pad, clocked by the pulse itself.
  always_ff @(posedge sum0_Pad or negedge RSTN_Pad)
    if (!RSTN_Pad) tog0 <= 1'b0;
    else           tog0 <= ~tog0;

  always_ff @(posedge sum1_Pad or negedge RSTN_Pad)
    if (!RSTN_Pad) tog1 <= 1'b0;
    else           tog1 <= ~tog1;

  always_ff @(posedge cout_Pad or negedge RSTN_Pad)
    if (!RSTN_Pad) tog2 <= 1'b0;
    else           tog2 <= ~tog2;

  // Two-stage synchronizer plus one history stage; a toggle change between
  // consecutive synchronized samples means one pulse in that window. Two
  // pulses in one window cancel out.
  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad)
    if (!RSTN_Pad) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {tog2, tog1, tog0};
      sync2 <= sync1;
      sync3 <= sync2;
    end

  assign got = sync2 ^ sync3;

  logic [STAGES-1:0] dl_v;
  logic [2:0]        dl_w [STAGES];
  logic              head_v;
  logic [2:0]        head_w;

  // Expectation delay line, always shifting, no backpressure.
  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad)
    if (!RSTN_Pad) begin
      dl_v <= '0;
      for (int i = 0; i < STAGES; i++) dl_w[i] <= '0;
    end else begin
      dl_v    <= {dl_v[STAGES-2:0], exp_valid};
      dl_w[0] <= exp_word;
      for (int i = 1; i < STAGES; i++) dl_w[i] <= dl_w[i-1];
    end

  assign head_v = dl_v[STAGES-1];
  assign head_w = dl_w[STAGES-1];

  logic match, mismatch_ev, spur_ev;
  assign match       = (got == head_w);
  assign mismatch_ev = head_v && !match;
  assign spur_ev     = !head_v && (got != 3'b000);

  // Compare result and statistics; clr wins over this cycle's updates.
  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad)
    if (!RSTN_Pad) begin
      chk_valid      <= 1'b0;
      chk_pass       <= 1'b0;
      got_word       <= '0;
      err_count      <= '0;
      chk_count      <= '0;
      spurious       <= 1'b0;
      first_err_vld  <= 1'b0;
      first_err_info <= '0;
    end else begin
      chk_valid <= head_v;
      chk_pass  <= head_v && match;
      if (head_v) got_word <= got;
      if (clr) begin
        err_count      <= '0;
        chk_count      <= '0;
        spurious       <= 1'b0;
        first_err_vld  <= 1'b0;
        first_err_info <= '0;
      end else begin
        if ((mismatch_ev || spur_ev) && (err_count != '1))
          err_count <= err_count + CNT_W'(1);
        if (head_v && (chk_count != '1))
          chk_count <= chk_count + CNT_W'(1);
        if (spur_ev) spurious <= 1'b1;
        if (mismatch_ev && !first_err_vld) begin
          first_err_vld  <= 1'b1;
          first_err_info <= {head_w, got};
        end
      end
    end

`ifdef KSA2_RESULT_LOG_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, next_rd;
  logic [AW:0]   count, remain;
  logic [3:0]    push_data, rd_data_q;
  logic          full, do_pop, do_push, overflow_q;

  assign push_data = {~match, got};
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = log_rd_en && (count != '0);
  // A pop frees a slot in the same cycle, so a push at full still fits.
  assign do_push   = head_v && (!full || do_pop);
  assign next_rd   = do_pop ? rd_ptr + AW'(1) : rd_ptr;
  assign remain    = count - (AW+1)'(do_pop);

  // Storage array, no reset needed.
  always_ff @(posedge GCLK_Pad)
    if (do_push) mem[wr_ptr] <= push_data;

  // Pointers, occupancy and overflow flag. The read data register follows
  // the head of the queue and keeps its last value once the queue drains.
  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad)
    if (!RSTN_Pad) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= next_rd;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (remain != '0)  rd_data_q <= mem[next_rd];
      else if (do_push)  rd_data_q <= push_data;
      if (clr)                  overflow_q <= 1'b0;
      else if (head_v && !do_push) overflow_q <= 1'b1;
    end

  assign log_rd_data  = rd_data_q;
  assign log_empty    = (count == '0);
  assign log_full     = full;
  assign log_overflow = overflow_q;
`else
  localparam int depth_unused = DEPTH;
  logic log_rd_unused;
  assign log_rd_unused = log_rd_en;

  assign log_rd_data  = 4'b0000;
  assign log_empty    = 1'b1;
  assign log_full     = 1'b0;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ksa2_result_checker.sv
// tb_ksa2_result_checker
//   Directed and random stimulus for ksa2_result_checker. An adder stand-in
//   emits its result pulses LATENCY windows after each expectation, and a
//   reference model tracks expected outputs from per-window histories.
module tb_ksa2_result_checker;
  localparam int L = 2;
  localparam int D = 8;
  localparam int W = 8;
  localparam int SAT = (1 << W) - 1;

  logic         GCLK_Pad, RSTN_Pad, sum0_Pad, sum1_Pad, cout_Pad;
  logic         exp_valid, clr, log_rd_en;
  logic [2:0]   exp_word;
  logic         chk_valid, chk_pass, spurious, first_err_vld;
  logic [2:0]   got_word;
  logic [W-1:0] err_count, chk_count;
  logic [5:0]   first_err_info;
  logic [3:0]   log_rd_data;
  logic         log_empty, log_full, log_overflow;

  ksa2_result_checker #(.LATENCY(L), .DEPTH(D), .CNT_W(W)) dut (
    .GCLK_Pad(GCLK_Pad), .RSTN_Pad(RSTN_Pad),
    .sum0_Pad(sum0_Pad), .sum1_Pad(sum1_Pad), .cout_Pad(cout_Pad),
    .exp_valid(exp_valid), .exp_word(exp_word), .clr(clr),
    .chk_valid(chk_valid), .chk_pass(chk_pass), .got_word(got_word),
    .err_count(err_count), .chk_count(chk_count), .spurious(spurious),
    .first_err_vld(first_err_vld), .first_err_info(first_err_info),
    .log_rd_en(log_rd_en), .log_rd_data(log_rd_data),
    .log_empty(log_empty), .log_full(log_full), .log_overflow(log_overflow)
  );

  initial GCLK_Pad = 1'b0;
  always #5 GCLK_Pad = ~GCLK_Pad;

  int vectors = 0;
  int miscompares = 0;

  // Per-window history since the last reset.
  bit         ev_hist[$];
  logic [2:0] ew_hist[$];
  logic [2:0] pw_hist[$];
  logic [2:0] sched[int];
  int         stepNo = 0;

  // Expected output state.
  int         m_err, m_chk;
  bit         m_spur, m_fev, m_cv, m_pass, m_ovf;
  logic [5:0] m_finfo;
  logic [2:0] m_got;
  logic [3:0] m_log[$];
  logic [3:0] m_rd;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    ev_hist.delete(); ew_hist.delete(); pw_hist.delete(); sched.delete();
    m_err = 0; m_chk = 0; m_spur = 0; m_fev = 0; m_cv = 0; m_pass = 0;
    m_ovf = 0; m_finfo = '0; m_got = '0; m_log.delete(); m_rd = '0;
  endtask

  // What the checker should have done at the edge that closed this window.
  task automatic modelEdge(bit ev, logic [2:0] ew, logic [2:0] pw, bit rd, bit cl);
    int n;
    bit hv, mis, spur;
    logic [2:0] hw, g;
    ev_hist.push_back(ev); ew_hist.push_back(ew); pw_hist.push_back(pw);
    n  = ev_hist.size() - 1;
    g  = (n >= 2) ? pw_hist[n-2] : 3'b000;
    hv = (n >= L + 2) ? ev_hist[n-L-2] : 1'b0;
    hw = (n >= L + 2) ? ew_hist[n-L-2] : 3'b000;
    mis  = hv && (g != hw);
    spur = !hv && (g != 3'b000);
    m_cv = hv;
    m_pass = hv && !mis;
    if (hv) m_got = g;
    if (cl) begin
      m_err = 0; m_chk = 0; m_spur = 0; m_fev = 0; m_finfo = '0;
    end else begin
      if ((mis || spur) && m_err < SAT) m_err++;
      if (hv && m_chk < SAT) m_chk++;
      if (spur) m_spur = 1;
      if (mis && !m_fev) begin m_fev = 1; m_finfo = {hw, g}; end
    end
`ifdef KSA2_RESULT_LOG_EN
    if (rd && m_log.size() > 0) void'(m_log.pop_front());
    if (hv) begin
      if (m_log.size() < D) m_log.push_back({mis, g});
      else if (!cl) m_ovf = 1;
    end
    if (cl) m_ovf = 0;
    if (m_log.size() > 0) m_rd = m_log[0];
`endif
  endtask

  task automatic checkOutput();
    cmp("chk_valid", 32'(chk_valid), 32'(m_cv));
    if (m_cv) begin
      cmp("chk_pass", 32'(chk_pass), 32'(m_pass));
      cmp("got_word", 32'(got_word), 32'(m_got));
    end
    cmp("err_count", 32'(err_count), 32'(m_err));
    cmp("chk_count", 32'(chk_count), 32'(m_chk));
    cmp("spurious", 32'(spurious), 32'(m_spur));
    cmp("first_err_vld", 32'(first_err_vld), 32'(m_fev));
    cmp("first_err_info", 32'(first_err_info), 32'(m_finfo));
    cmp("log_rd_data", 32'(log_rd_data), 32'(m_rd));
    cmp("log_empty", 32'(log_empty), 32'(m_log.size() == 0));
    cmp("log_full", 32'(log_full), 32'(m_log.size() == D));
    cmp("log_overflow", 32'(log_overflow), 32'(m_ovf));
  endtask

  task automatic checkReset();
    checkOutput();
    cmp("rst_chk_pass", 32'(chk_pass), 32'd0);
    cmp("rst_got_word", 32'(got_word), 32'd0);
  endtask

  // One GCLK window: drive expectation/controls, fire pad pulses (scheduled
  // adder result plus any extra), then check just after the closing edge.
  task automatic applyStimulus(bit ev, logic [2:0] ew, logic [2:0] aw,
                               logic [2:0] extra, bit rd, bit cl);
    logic [2:0] pw;
    pw = extra;
    if (sched.exists(stepNo)) pw = pw | sched[stepNo];
    if (ev) sched[stepNo + L] = aw;
    exp_valid = ev; exp_word = ew; log_rd_en = rd; clr = cl;
    #1; sum0_Pad = pw[0]; sum1_Pad = pw[1]; cout_Pad = pw[2];
    #1; sum0_Pad = 1'b0; sum1_Pad = 1'b0; cout_Pad = 1'b0;
    @(posedge GCLK_Pad);
    modelEdge(ev, ew, pw, rd, cl);
    stepNo++;
    #1;
    checkOutput();
  endtask

  task automatic idle(int n, bit rd);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'b000, 3'b000, 3'b000, rd, 1'b0);
  endtask

  // Reset asserted mid-window while all pads are pulsing.
  task automatic doReset();
    exp_valid = 0; exp_word = 0; log_rd_en = 0; clr = 0;
    #1 {cout_Pad, sum1_Pad, sum0_Pad} = 3'b111;
    #1 RSTN_Pad = 1'b0;
    #1 {cout_Pad, sum1_Pad, sum0_Pad} = 3'b000;
    resetModel();
    #1 checkReset();
    @(posedge GCLK_Pad);
    #1 checkReset();
    #3 RSTN_Pad = 1'b1;
  endtask

  function automatic logic [2:0] add2(int a, int b, int cin);
    return 3'(a + b + cin);
  endfunction

  initial begin
    logic [2:0] w, aw;
    RSTN_Pad = 1'b1; sum0_Pad = 0; sum1_Pad = 0; cout_Pad = 0;
    exp_valid = 0; exp_word = 0; clr = 0; log_rd_en = 0;

    doReset();
    idle(3, 0);

    // Correct sum: 3+1+1 -> adder pulses cout and sum0.
    applyStimulus(1, add2(3, 1, 1), 3'b101, 3'b000, 0, 0);
    idle(L + 2, 0);

    // Mismatch: 3+3+0 expected 110, only sum1 arrives; then a second one.
    applyStimulus(1, add2(3, 3, 0), 3'b010, 3'b000, 0, 0);
    idle(L + 2, 0);
    applyStimulus(1, add2(1, 0, 0), 3'b000, 3'b000, 0, 0);
    idle(L + 2, 0);

    // Spurious cout pulse with nothing expected.
    applyStimulus(0, 3'b000, 3'b000, 3'b100, 0, 0);
    idle(L + 2, 0);

    // Drain log, clear stats, then 9 consecutive checks with no pops.
    idle(4, 1);
    applyStimulus(0, 3'b000, 3'b000, 3'b000, 0, 1);
    for (int i = 0; i < 9; i++) begin
      w = add2(i % 4, (i + 1) % 4, i % 2);
      applyStimulus(1, w, w, 3'b000, 0, 0);
    end
    idle(L + 2, 0);
    // Clear overflow, then push and pop together while full.
    applyStimulus(0, 3'b000, 3'b000, 3'b000, 0, 1);
    for (int i = 0; i < L + 4; i++)
      applyStimulus(i < 2, 3'b011, 3'b011, 3'b000, i >= L + 2, 0);
    idle(8, 1);
    idle(2, 0);

    // Saturation: 300 mismatches, then clr coinciding with a mismatch.
    for (int i = 0; i < 300; i++) applyStimulus(1, 3'b001, 3'b000, 3'b000, 0, 0);
    idle(L + 2, 0);
    for (int i = 0; i < L + 3; i++)
      applyStimulus(i == 0, 3'b111, 3'b000, 3'b000, 0, i == L + 2);
    idle(2, 0);

    // Reset with expectations in flight; they must not surface.
    applyStimulus(1, 3'b101, 3'b101, 3'b000, 0, 0);
    applyStimulus(1, 3'b110, 3'b110, 3'b000, 0, 0);
    doReset();
    idle(L + 3, 0);
    applyStimulus(1, add2(2, 2, 1), 3'b101, 3'b000, 0, 0);
    idle(L + 2, 0);

    // Random traffic with occasional adder faults, spurious pulses and clr.
    for (int i = 0; i < 400; i++) begin
      bit ev;
      ev = 1'($urandom_range(0, 1));
      w  = add2($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      aw = ($urandom_range(0, 3) == 0) ? (w ^ 3'($urandom_range(1, 7))) : w;
      applyStimulus(ev, w, aw,
                    ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                    1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    end
    idle(L + 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
